float_to_int_converter: RTL and testbench
=========================================

// Module: float_to_int_converter
// PURPOSE
//   Converts the team's 13-bit sign/exponent/significand float back to an 8-bit two's-complement integer.
//   Inverse of the int-to-float path; closes the round trip in the conversion datapath.
//   Multi-cycle iterative shifter behind valid/ready handshakes on both sides.
//   Flags saturation (overflow) and truncated fraction bits (inexact).
// PARAMETERS
//   EXP_W   4  exponent field width (unsigned, unbiased)
//   FRAC_W  8  significand field width; INT_W must equal FRAC_W
//   INT_W   8  output integer width, two's complement
// PORTS
//   clk        in   1       clock, all logic on rising edge
//   rst_n      in   1       synchronous reset, active-low
//   float_i    in   13      {sign[12], exp[11:8], frac[7:0]}
//   valid_i    in   1       float_i valid
//   ready_o    out  1       converter can accept (IDLE only)
//   int_o      out  8       converted integer, registered
//   overflow_o out  1       result saturated
//   inexact_o  out  1       nonzero fraction bits discarded
//   valid_o    out  1       int_o/flags valid
//   ready_i    in   1       downstream accepts result
// BEHAVIOUR
//   - Value = (-1)^S * (F/2^FRAC_W) * 2^E, where F = frac (unsigned) and E = exp (unsigned). Conversion truncates toward zero.
//   - Reset (rst_n=0 at an edge): state=IDLE; int_o=0, overflow_o=0, inexact_o=0, valid_o=0, ready_o=1.
//     Reset mid-conversion discards the in-flight value. No result is emitted.
//   - FSM IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: ready_o=1. On valid_i&&ready_o, capture S, mag=F, sticky=0.
//     ovf = (E>FRAC_W). k = ovf ? 0 : FRAC_W-E. cnt=k. Go to SHIFT.
//   - SHIFT: ready_o=0.
//     If cnt!=0: mag = mag>>1; sticky |= mag[0] (bit shifted out); cnt = cnt-1.
//     If cnt==0: register the result and flags, set valid_o=1, go to DONE.
//   - Result rules, in priority order:
//     ovf -> saturate (S ? 0x80 : 0x7F), overflow_o=1.
//     S=0 and mag>127 -> 0x7F, overflow_o=1.
//     S=1 and mag>128 -> 0x80, overflow_o=1.
//     Otherwise int_o = S ? -mag : mag. A mag of 0 gives 0x00 for either sign.
//   - inexact_o = sticky. It is forced to 0 when overflow_o=1.
//   - Latency: valid_o rises k+1 cycles after the accepting edge.
//   - DONE: valid_o=1. int_o and flags are held stable while ready_i=0.
//     On valid_o&&ready_i, drop valid_o and go to IDLE. ready_o rises the following cycle; no same-cycle accept.
//   - A non-normalized frac (F[7]=0, F!=0) is handled arithmetically. There is no error flag for it.
//   - valid_i is ignored outside IDLE. float_i is sampled only on the accepting edge.
// TESTING
//   1. 0_0111_11111110 -> int_o=0x7F, ovf=0, inexact=0, valid_o 2 cycles after accept.
//   2. 1_1000_10000000 -> int_o=0x80 (-128), ovf=0, valid_o 1 cycle after accept.
//      0_1000_10000000 -> int_o=0x7F, ovf=1.
//   3. 0_0011_10110000 (5.5) -> int_o=0x05, inexact=1, valid_o 6 cycles after accept.
//      1_0000_10000000 (-0.5) -> int_o=0x00, inexact=1, 9 cycles.
//   4. 0_1001_10000000 (E>8) -> int_o=0x7F, ovf=1, inexact=0, 1 cycle.
//      Same float with S=1 -> int_o=0x80.
//   5. Hold ready_i=0 for 5 cycles in DONE -> int_o/flags stable, ready_o=0.
//      Pulse rst_n=0 mid-SHIFT -> all outputs 0, ready_o=1, no valid_o.
//   6. Round trip: all 256 ints through int_to_float_converter, then this block ->
//      original int returned, ovf=0, inexact=0.
//      Also run an exhaustive sweep of all 8192 floats against the reference model.

Source files
------------

// File: rtl/float_to_int_converter.sv
// float_to_int_converter
//   Converts a sign/exponent/significand float {sign, exp[EXP_W-1:0], frac[FRAC_W-1:0]}
//   with value (-1)^S * (F / 2^FRAC_W) * 2^E into an INT_W-bit two's-complement integer.
//   Truncates toward zero, using one right shift per cycle. Out-of-range results saturate
//   and raise overflow_o. inexact_o reports nonzero fraction bits that were discarded.
//   The input and the output each use a valid/ready handshake.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   float_i    {sign, exp, frac}, sampled only on the accepting edge
//   valid_i    float_i valid
//   ready_o    converter idle and able to accept
//   int_o      converted integer (registered)
//   overflow_o result saturated
//   inexact_o  nonzero fraction bits discarded (never set together with overflow_o)
//   valid_o    int_o and flags valid
//   ready_i    downstream accepts the result
module float_to_int_converter #(
    parameter int unsigned EXP_W  = 4,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned INT_W  = 8   // must equal FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [EXP_W+FRAC_W:0]   float_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [INT_W-1:0]        int_o,
    output logic                    overflow_o,
    output logic                    inexact_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int unsigned CntW = $clog2(FRAC_W + 1);

    localparam logic [INT_W-1:0]  IntMax = {1'b0, {(INT_W - 1){1'b1}}};
    localparam logic [INT_W-1:0]  IntMin = {1'b1, {(INT_W - 1){1'b0}}};
    localparam logic [FRAC_W-1:0] MagMaxPos = FRAC_W'((1 << (INT_W - 1)) - 1);
    localparam logic [FRAC_W-1:0] MagMaxNeg = FRAC_W'(1 << (INT_W - 1));

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e state_q, state_d;

    logic              sign_q, sign_d;
    logic [FRAC_W-1:0] mag_q, mag_d;
    logic              sticky_q, sticky_d;
    logic              ovf_q, ovf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [INT_W-1:0]  int_q, int_d;
    logic              overflow_q, overflow_d;
    logic              inexact_q, inexact_d;

    logic [EXP_W-1:0]  exp_f;
    logic              exp_ovf;
    logic [CntW-1:0]   shift_k;
    logic              accept;

    logic [INT_W-1:0]  res_int;
    logic              res_ovf;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            sticky_q   <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            int_q      <= '0;
            overflow_q <= 1'b0;
            inexact_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            sticky_q   <= sticky_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            int_q      <= int_d;
            overflow_q <= overflow_d;
            inexact_q  <= inexact_d;
        end
    end

    // Shift count: the binary point sits FRAC_W bits left of the significand LSB, so an
    // exponent of E needs FRAC_W-E right shifts. E > FRAC_W cannot fit and saturates.
    always_comb begin
        exp_f   = float_i[FRAC_W +: EXP_W];
        exp_ovf = (32'(exp_f) > FRAC_W);
        shift_k = exp_ovf ? '0 : CntW'(FRAC_W - 32'(exp_f));
        accept  = valid_i && (state_q == StIdle);
    end

    // Final result from the fully shifted magnitude
    always_comb begin
        res_int = '0;
        res_ovf = 1'b0;
        if (ovf_q) begin
            res_int = sign_q ? IntMin : IntMax;
            res_ovf = 1'b1;
        end else if (!sign_q && (mag_q > MagMaxPos)) begin
            res_int = IntMax;
            res_ovf = 1'b1;
        end else if (sign_q && (mag_q > MagMaxNeg)) begin
            res_int = IntMin;
            res_ovf = 1'b1;
        end else begin
            // Negating 0 yields 0, so -0.x comes out as 0x00.
            res_int = sign_q ? INT_W'(~mag_q + FRAC_W'(1)) : INT_W'(mag_q);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StShift;
            StShift: if (cnt_q == '0) state_d = StDone;
            StDone:  if (ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        sign_d     = sign_q;
        mag_d      = mag_q;
        sticky_d   = sticky_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        int_d      = int_q;
        overflow_d = overflow_q;
        inexact_d  = inexact_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sign_d   = float_i[EXP_W + FRAC_W];
                    mag_d    = float_i[FRAC_W-1:0];
                    sticky_d = 1'b0;
                    ovf_d    = exp_ovf;
                    cnt_d    = shift_k;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    mag_d    = mag_q >> 1;
                    sticky_d = sticky_q | mag_q[0];
                    cnt_d    = cnt_q - CntW'(1);
                end else begin
                    int_d      = res_int;
                    overflow_d = res_ovf;
                    inexact_d  = sticky_q & ~res_ovf;
                end
            end
            StDone: ;
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        ready_o    = (state_q == StIdle);
        valid_o    = (state_q == StDone);
        int_o      = int_q;
        overflow_o = overflow_q;
        inexact_o  = inexact_q;
    end

endmodule

// File: tb/tb_float_to_int_converter.sv
module tb_float_to_int_converter;

    logic        clk;
    logic        rst_n;
    logic [12:0] float_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  int_o;
    logic        overflow_o;
    logic        inexact_o;
    logic        valid_o;
    logic        ready_i;

    int applied;
    int miscompares;

    float_to_int_converter #(
        .EXP_W  (4),
        .FRAC_W (8),
        .INT_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .float_i    (float_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .int_o      (int_o),
        .overflow_o (overflow_o),
        .inexact_o  (inexact_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (applied %0d)", applied);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        applied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: value = F * 2^E / 256, truncated toward zero, then saturated.
    function automatic void ref_model(input logic [12:0] f, output logic [7:0] r,
                                      output logic ov, output logic inx, output int lat);
        logic s;
        int   e;
        int   fr;
        int   p;
        int   ip;
        s  = f[12];
        e  = int'(f[11:8]);
        fr = int'(f[7:0]);
        if (e > 8) begin
            r   = s ? 8'h80 : 8'h7F;
            ov  = 1'b1;
            inx = 1'b0;
            lat = 1;
        end else begin
            p   = fr * (1 << e);
            ip  = p / 256;
            lat = 8 - e + 1;
            if (!s && ip > 127) begin
                r = 8'h7F; ov = 1'b1; inx = 1'b0;
            end else if (s && ip > 128) begin
                r = 8'h80; ov = 1'b1; inx = 1'b0;
            end else begin
                r   = s ? 8'(-ip) : 8'(ip);
                ov  = 1'b0;
                inx = (p % 256) != 0;
            end
        end
    endfunction

    // Normalising int -> float encoder (the forward path of the round trip)
    function automatic logic [12:0] int_to_float(input int v);
        logic s;
        int   m;
        int   e;
        int   fr;
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return {s, 12'h000};
        e = 0;
        while ((1 << e) <= m) e++;
        fr = m << (8 - e);
        return {s, 4'(e), 8'(fr)};
    endfunction

    // One full transaction; valid_i is left high with junk data while busy to show it is ignored.
    task automatic convert(input string tag, input logic [12:0] f, input logic [7:0] er,
                           input logic eov, input logic einx, input int elat, input int hold);
        int lat;
        check({tag, "_ready_before"}, ready_o, 1);
        float_i = f;
        valid_i = 1'b1;
        @(posedge clk); #1;
        float_i = ~f;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, elat);
        check({tag, "_int"}, int_o, er);
        check({tag, "_ovf"}, overflow_o, eov);
        check({tag, "_inexact"}, inexact_o, einx);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, valid_o, 1);
            check({tag, "_hold_int"}, int_o, er);
            check({tag, "_hold_ovf"}, overflow_o, eov);
            check({tag, "_hold_inexact"}, inexact_o, einx);
            check({tag, "_hold_ready"}, ready_o, 0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check({tag, "_valid_drop"}, valid_o, 0);
        check({tag, "_ready_after"}, ready_o, 1);
    endtask

    initial begin
        logic [7:0]  er;
        logic        eov;
        logic        einx;
        int          elat;
        logic [12:0] f;

        applied     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        float_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_int", int_o, 0);
        check("reset_ovf", overflow_o, 0);
        check("reset_inexact", inexact_o, 0);
        check("reset_valid", valid_o, 0);
        check("reset_ready", ready_o, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-computed expectations
        convert("t1_254x2^-1", 13'b0_0111_11111110, 8'h7F, 1'b0, 1'b0, 2, 0);
        convert("t2_neg128",   13'b1_1000_10000000, 8'h80, 1'b0, 1'b0, 1, 0);
        convert("t2_pos128",   13'b0_1000_10000000, 8'h7F, 1'b1, 1'b0, 1, 0);
        convert("t3_5p5",      13'b0_0011_10110000, 8'h05, 1'b0, 1'b1, 6, 0);
        convert("t3_neg0p5",   13'b1_0000_10000000, 8'h00, 1'b0, 1'b1, 9, 0);
        convert("t4_e9_pos",   13'b0_1001_10000000, 8'h7F, 1'b1, 1'b0, 1, 0);
        convert("t4_e9_neg",   13'b1_1001_10000000, 8'h80, 1'b1, 1'b0, 1, 0);
        convert("neg5p5",      13'b1_0011_10110000, 8'hFB, 1'b0, 1'b1, 6, 0);
        convert("denorm_3",    13'b0_1000_00000011, 8'h03, 1'b0, 1'b0, 1, 0);
        convert("neg_ovf",     13'b1_1000_10000001, 8'h80, 1'b1, 1'b0, 1, 0);
        convert("t5_hold",     13'b0_0110_10100101, 8'h29, 1'b0, 1'b1, 3, 5);

        // Reset in the middle of a long shift: nothing may emerge
        float_i = 13'b0_0011_10110000;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_busy", ready_o, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_int", int_o, 0);
        check("midrst_ovf", overflow_o, 0);
        check("midrst_inexact", inexact_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_ready", ready_o, 1);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_valid", valid_o, 0);
        check("midrst_still_ready", ready_o, 1);

        // Round trip over every 8-bit integer
        for (int v = -128; v < 128; v++) begin
            f = int_to_float(v);
            ref_model(f, er, eov, einx, elat);
            convert($sformatf("rt_%0d", v), f, 8'(v), 1'b0, 1'b0, elat, 0);
        end

        // Exhaustive sweep against the reference model
        for (int i = 0; i < 8192; i++) begin
            f = 13'(i);
            ref_model(f, er, eov, einx, elat);
            convert($sformatf("sw_%04h", i), f, er, eov, einx, elat, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
